// File: rtl/state_report.sv
// state_report: snapshots the AWG control fields on request and streams them
// as an ASCII frame "f<s><f><a><p>" [CR LF] over a valid/ready byte interface.
//
// Ports:
//   clk, rst            clock; async active-high reset
//   report_req          one-cycle request to send a frame
//   state[4:0]          waveform select field
//   state_freq[7:0]     frequency field
//   state_amp[7:0]      amplitude field
//   state_phase[7:0]    phase field
//   tx_data[7:0]        current frame byte
//   tx_valid, tx_ready  byte stream handshake
//   busy                frame in progress
//   done                one-cycle pulse after the last byte is accepted
//   range_err           with done: some field in the frame was > 9
//
// Build option: define STATE_REPORT_CRLF_EN to terminate frames with CR LF.
module state_report (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic [4:0] state,
  input  logic [7:0] state_freq,
  input  logic [7:0] state_amp,
  input  logic [7:0] state_phase,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       range_err
);

  localparam logic [7:0] HEADER   = 8'h66;
  localparam logic [7:0] BAD_CHAR = 8'h3F;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;

`ifdef STATE_REPORT_CRLF_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [2:0] idx_q, idx_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       load;
  logic       new_err;
  logic [7:0] frame_byte;

  logic [4:0] snap_state_q;
  logic [7:0] snap_freq_q;
  logic [7:0] snap_amp_q;
  logic [7:0] snap_phase_q;

  function automatic logic bad(input logic [7:0] v);
    return v > 8'd9;
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] v);
    if (bad(v))
      return BAD_CHAR;
    return 8'h30 + {4'h0, v[3:0]};
  endfunction

  // The whole width is compared, so e.g. 16 or 19 report '?'.
  assign new_err = bad({3'b000, state}) | bad(state_freq) |
                   bad(state_amp) | bad(state_phase);

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = enc({3'b000, snap_state_q});
      3'd2:    frame_byte = enc(snap_freq_q);
      3'd3:    frame_byte = enc(snap_amp_q);
      3'd4:    frame_byte = enc(snap_phase_q);
      3'd5:    frame_byte = CR;
      3'd6:    frame_byte = LF;
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    err_d     = err_q;
    load      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = (fsm_q != IDLE);
    done      = 1'b0;
    range_err = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (report_req)
          load = 1'b1;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = frame_byte;
        if (report_req)
          pend_d = 1'b1;
        if (tx_ready) begin
          if (idx_q == LAST_IDX)
            fsm_d = DONE;
          else
            idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        done      = 1'b1;
        range_err = err_q;
        // A request landing in this cycle is treated as pending.
        if (pend_q || report_req)
          load = 1'b1;
        else
          fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    if (load) begin
      fsm_d  = SEND;
      idx_d  = 3'd0;
      pend_d = 1'b0;
      err_d  = new_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= IDLE;
      idx_q        <= 3'd0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      snap_state_q <= 5'd0;
      snap_freq_q  <= 8'd0;
      snap_amp_q   <= 8'd0;
      snap_phase_q <= 8'd0;
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      if (load) begin
        snap_state_q <= state;
        snap_freq_q  <= state_freq;
        snap_amp_q   <= state_amp;
        snap_phase_q <= state_phase;
      end
    end
  end

endmodule

// File: doc/state_report.md
# state_report

Status reporter for the AWG command interface: on request it snapshots the four control fields (`state`, `state_freq`, `state_amp`, `state_phase`) and serialises them as an ASCII frame, e.g. `f3111` CR LF, one byte at a time over a valid/ready byte stream toward the UART transmitter. It is the outbound counterpart of the command parser and uses the same digit-per-field format, so a host can read back the active settings in the syntax it writes.

## Interface
- `HEADER`, 8'h66 ("f"), first byte of every frame.
- `BAD_CHAR`, 8'h3F ("?"), byte emitted for a field value outside 0..9.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `report_req`  in  1  single-cycle request to send one frame.
- `state`  in  5  waveform select field.
- `state_freq`  in  8  frequency field.
- `state_amp`  in  8  amplitude field.
- `state_phase`  in  8  phase field.
- `tx_data`  out  8  current frame byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  downstream accepts the byte on this edge.
- `busy`  out  1  a frame is in progress (FSM not IDLE).
- `done`  out  1  one-cycle pulse after the last byte of a frame is accepted.
- `range_err`  out  1  valid with `done`: at least one field in the frame was > 9.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE: `report_req`=1 captures all four fields into snapshot registers, clears byte index to 0, clears frame error → SEND.
- SEND: `tx_valid`=1, `tx_data` = frame byte[index]. On `tx_valid && tx_ready` increment index; after the last byte is accepted → DONE.
- Frame bytes in order: `HEADER`, enc(state), enc(state_freq), enc(state_amp), enc(state_phase), then CR (8'h0D) and LF (8'h0A) when the macro is enabled.
- enc(v): v in 0..9 → 8'h30 + v[3:0]; v > 9 (full input width compared, including upper bits) → `BAD_CHAR`, and the frame error is set.
- DONE: one cycle; `done`=1, `range_err` = frame error, `tx_valid`=0. Next: SEND with a fresh snapshot if a request is pending, else IDLE.
- Fields are sampled only at frame start; input changes during a frame do not alter the frame in flight.
- `report_req` while not IDLE sets a one-deep pending flag; further requests while the flag is set are dropped. Pending is cleared when the new frame starts.
- `report_req` during the DONE cycle counts as pending.

## Timing
- Reset values: `tx_data`=8'h00, `tx_valid`=0, `busy`=0, `done`=0, `range_err`=0, FSM=IDLE, index=0, pending=0, snapshot=0.
- Assertion of `rst` mid-frame drops `tx_valid` immediately and abandons the frame; no `done` is produced.
- Latency: request sampled at edge N → `tx_valid`=1 with `HEADER` from edge N.
- `tx_valid` is never deasserted and `tx_data` never changes while a byte is waiting for `tx_ready`.
- `tx_ready` held at 1: one byte per cycle; 7-byte frame accepted on edges N+1..N+7, `done` high for the cycle after edge N+7.
- Back-to-back frames: exactly one gap cycle (DONE) between the last byte of one frame and `HEADER` of the next.
- `busy` is high in SEND and DONE.
- `range_err` is driven as 0 outside the DONE cycle.

## Configuration
- `STATE_REPORT_CRLF_EN` defined: frame is 7 bytes, terminated by CR LF.
- Not defined: frame is 5 bytes (`HEADER` + 4 digits); `done` follows acceptance of the phase digit.

## Test plan
- Fields 3/1/1/1, `tx_ready`=1, single request → bytes 66 33 31 31 31 0D 0A on consecutive cycles, `done` once, `range_err`=0.
- Fields 2/9/0/5, `tx_ready` toggled 1,0,0,1,... → each byte held stable until accepted, sequence 66 32 39 30 35 0D 0A, no byte repeated or skipped.
- Fields state=10, freq=8'd200, amp=4, phase=7 → 66 3F 3F 34 37 0D 0A, `range_err`=1 with `done`.
- Request then amp changed 1→6 mid-frame, second request during frame, third during frame → first frame shows amp `1`; exactly one more frame follows after one gap cycle, showing `6`; the third request is dropped.
- `rst` asserted after third byte accepted → `tx_valid`, `busy` low immediately, no `done`; next request after reset emits a full frame starting at 66.
- Macro undefined, fields 1/2/3/4 → 66 31 32 33 34, `done` on the cycle after 34 is accepted.
